// File: rtl/fifo_write_arbiter_if.sv
// Producer-side bundle for fifo_write_arbiter: requests, packed data, FIFO full, grant and write strobe.
// FIFO_ARB_STALL_CNT_EN adds the stall_count_o signal to the bundle.
interface fifo_write_arbiter_if #(
  parameter int unsigned NUM_REQUESTERS = 4,
  parameter int unsigned DATA_SIZE      = 8
);
  logic [NUM_REQUESTERS-1:0]           request_i;
  logic [NUM_REQUESTERS*DATA_SIZE-1:0] data_i;
  logic                                write_full_i;
  logic [NUM_REQUESTERS-1:0]           grant_o;
  logic                                write_increment_o;
  logic [DATA_SIZE-1:0]                write_data_o;
  logic                                busy_o;
`ifdef FIFO_ARB_STALL_CNT_EN
  logic [15:0]                         stall_count_o;

  modport master (
    input  request_i, data_i, write_full_i,
    output grant_o, write_increment_o, write_data_o, busy_o, stall_count_o
  );
  modport slave (
    output request_i, data_i, write_full_i,
    input  grant_o, write_increment_o, write_data_o, busy_o, stall_count_o
  );
`else
  modport master (
    input  request_i, data_i, write_full_i,
    output grant_o, write_increment_o, write_data_o, busy_o
  );
  modport slave (
    output request_i, data_i, write_full_i,
    input  grant_o, write_increment_o, write_data_o, busy_o
  );
`endif
endinterface

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing the async FIFO write port among producers, with bounded bursts per grant.
// Optional macro FIFO_ARB_STALL_CNT_EN adds a saturating count of full-stalled grant cycles.
module fifo_write_arbiter #(
  parameter int unsigned NUM_REQUESTERS = 4,
  parameter int unsigned DATA_SIZE      = 8,
  parameter int unsigned MAX_BURST      = 4
) (
  input  logic                 write_clk_i,
  input  logic                 write_reset_n_i,
  fifo_write_arbiter_if.master arb
);

  localparam int unsigned OW = $clog2(NUM_REQUESTERS);
  localparam int unsigned CW = $clog2(MAX_BURST) + 1;

  typedef enum logic [0:0] {IDLE, BURST} state_e;

  state_e                    state_q, state_d;
  logic [NUM_REQUESTERS-1:0] grant_q, grant_d;
  logic [OW-1:0]             owner_q, owner_d;
  logic [OW-1:0]             last_owner_q, last_owner_d;
  logic [CW-1:0]             cnt_q, cnt_d;

  logic                      accept_c;
  logic                      release_c;
  logic [OW-1:0]             base_c;
  logic [OW-1:0]             scan_idx;
  logic                      pick_valid;
  logic [OW-1:0]             pick_idx;

  assign accept_c = (|(grant_q & arb.request_i)) & ~arb.write_full_i;

  // Round-robin scan starting just after the pointer; the pointer owner itself is checked last.
  always_comb begin
    base_c     = (state_q == BURST) ? owner_q : last_owner_q;
    scan_idx   = '0;
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int unsigned i = 1; i <= NUM_REQUESTERS; i++) begin
      scan_idx = OW'((32'(base_c) + i) % NUM_REQUESTERS);
      if (!pick_valid && arb.request_i[scan_idx]) begin
        pick_valid = 1'b1;
        pick_idx   = scan_idx;
      end
    end
  end

  always_ff @(posedge write_clk_i or negedge write_reset_n_i) begin
    if (!write_reset_n_i) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      owner_q      <= '0;
      last_owner_q <= OW'(NUM_REQUESTERS - 1);
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      cnt_q        <= cnt_d;
    end
  end

  // Next-state: release on burst limit or owner drop, and re-pick in the same edge.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    cnt_d        = cnt_q;
    release_c    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = BURST;
          grant_d = NUM_REQUESTERS'(1) << pick_idx;
          owner_d = pick_idx;
          cnt_d   = '0;
        end
      end
      BURST: begin
        if (accept_c) cnt_d = cnt_q + CW'(1);
        release_c = (accept_c && (cnt_q == CW'(MAX_BURST - 1))) || !arb.request_i[owner_q];
        if (release_c) begin
          last_owner_d = owner_q;
          cnt_d        = '0;
          if (pick_valid) begin
            grant_d = NUM_REQUESTERS'(1) << pick_idx;
            owner_d = pick_idx;
          end else begin
            state_d = IDLE;
            grant_d = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  assign arb.grant_o           = grant_q;
  assign arb.busy_o            = (state_q == BURST);
  assign arb.write_increment_o = accept_c;
  assign arb.write_data_o      = (state_q == BURST) ?
                                 arb.data_i[32'(owner_q) * DATA_SIZE +: DATA_SIZE] : '0;

`ifdef FIFO_ARB_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Cycles where a granted requester is ready but the FIFO is full.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((|(grant_q & arb.request_i)) && arb.write_full_i && (stall_cnt_q != 16'hFFFF))
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge write_clk_i or negedge write_reset_n_i) begin
    if (!write_reset_n_i) stall_cnt_q <= '0;
    else                  stall_cnt_q <= stall_cnt_d;
  end

  assign arb.stall_count_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter: burst limit, rotation, full stall, owner drop, async reset, max_burst=1.
module tb_fifo_write_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned DW = 8;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;
  int   stb;

  fifo_write_arbiter_if #(.NUM_REQUESTERS(NR), .DATA_SIZE(DW)) ifc ();
  fifo_write_arbiter_if #(.NUM_REQUESTERS(NR), .DATA_SIZE(DW)) ifc1 ();

  fifo_write_arbiter #(.NUM_REQUESTERS(NR), .DATA_SIZE(DW), .MAX_BURST(4)) u_dut (
    .write_clk_i     (clk),
    .write_reset_n_i (rst_n),
    .arb             (ifc.master)
  );

  fifo_write_arbiter #(.NUM_REQUESTERS(NR), .DATA_SIZE(DW), .MAX_BURST(1)) u_dut1 (
    .write_clk_i     (clk),
    .write_reset_n_i (rst_n),
    .arb             (ifc1.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    settle();
    rst_n = 1'b1;
    settle();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    stb   = 0;
    rst_n = 1'b0;
    ifc.request_i     = '0;
    ifc.data_i        = '0;
    ifc.write_full_i  = 1'b0;
    ifc1.request_i    = '0;
    ifc1.data_i       = '0;
    ifc1.write_full_i = 1'b0;

    // Reset state
    #1;
    check("rst_grant", 32'(ifc.grant_o), 32'h0);
    check("rst_inc",   32'(ifc.write_increment_o), 32'h0);
    check("rst_data",  32'(ifc.write_data_o), 32'h0);
    check("rst_busy",  32'(ifc.busy_o), 32'h0);
    tick();
    tick();
    rst_n = 1'b1;

    // Sole requester 0: 4-word burst, re-grant with no bubble
    ifc.request_i    = 4'b0001;
    ifc.data_i[7:0]  = 8'hA0;
    settle();
    check("t1_latency_inc", 32'(ifc.write_increment_o), 32'h0);
    tick();
    for (int k = 0; k < 6; k++) begin
      ifc.data_i[7:0] = 8'(8'hA0 + k);
      settle();
      check("t1_grant", 32'(ifc.grant_o), 32'h1);
      check("t1_inc",   32'(ifc.write_increment_o), 32'h1);
      check("t1_data",  32'(ifc.write_data_o), 32'(8'hA0 + k));
      tick();
    end
    ifc.request_i = 4'b0000;
    settle();
    check("t1_drop_inc", 32'(ifc.write_increment_o), 32'h0);
    tick();
    check("t1_idle_grant", 32'(ifc.grant_o), 32'h0);
    check("t1_idle_busy",  32'(ifc.busy_o), 32'h0);

    // All four requesting: 4-word bursts in order 0,1,2,3,0
    do_reset();
    for (int k = 0; k < 4; k++) ifc.data_i[k*8 +: 8] = 8'(8'hB0 + k);
    ifc.request_i = 4'b1111;
    tick();
    for (int r = 0; r < 20; r++) begin
      settle();
      check("t2_grant", 32'(ifc.grant_o), 32'(1) << ((r / 4) % 4));
      check("t2_inc",   32'(ifc.write_increment_o), 32'h1);
      check("t2_data",  32'(ifc.write_data_o), 32'(8'hB0 + (r / 4) % 4));
      if (ifc.write_increment_o) stb++;
      if (r == 15) check("t2_rotation_strobes", 32'(stb), 32'd16);
      tick();
    end
    check("t2_next_grant", 32'(ifc.grant_o), 32'h2);
    ifc.request_i = 4'b0000;
    tick();
    check("t2_idle_grant", 32'(ifc.grant_o), 32'h0);
    check("t2_idle_data",  32'(ifc.write_data_o), 32'h0);
    check("t2_idle_busy",  32'(ifc.busy_o), 32'h0);

    // Requester 2 stalled by full for 5 cycles after its 2nd word
    do_reset();
    ifc.data_i        = '0;
    ifc.data_i[7:0]   = 8'hC0;
    ifc.data_i[23:16] = 8'hC2;
    ifc.request_i     = 4'b0100;
    tick();
    settle();
    check("t3_grant", 32'(ifc.grant_o), 32'h4);
    check("t3_w0",    32'(ifc.write_increment_o), 32'h1);
    tick();
    check("t3_w1",    32'(ifc.write_increment_o), 32'h1);
    tick();
    ifc.write_full_i = 1'b1;
    ifc.request_i    = 4'b0101;
    for (int s = 0; s < 5; s++) begin
      settle();
      check("t3_stall_inc",   32'(ifc.write_increment_o), 32'h0);
      check("t3_stall_grant", 32'(ifc.grant_o), 32'h4);
      check("t3_stall_busy",  32'(ifc.busy_o), 32'h1);
      tick();
    end
    ifc.write_full_i = 1'b0;
    for (int w = 0; w < 2; w++) begin
      settle();
      check("t3_resume_inc",   32'(ifc.write_increment_o), 32'h1);
      check("t3_resume_grant", 32'(ifc.grant_o), 32'h4);
      check("t3_resume_data",  32'(ifc.write_data_o), 32'hC2);
      tick();
    end
    check("t3_rotate_grant", 32'(ifc.grant_o), 32'h1);
    check("t3_rotate_data",  32'(ifc.write_data_o), 32'hC0);
`ifdef FIFO_ARB_STALL_CNT_EN
    check("t3_stall_count", 32'(ifc.stall_count_o), 32'd5);
`endif
    ifc.request_i = 4'b0000;
    tick();
    check("t3_idle_grant", 32'(ifc.grant_o), 32'h0);

    // Owner 1 drops after one word; 3 follows 1 ahead of 0
    do_reset();
    ifc.data_i[15:8] = 8'hD1;
    ifc.request_i    = 4'b0010;
    tick();
    ifc.request_i = 4'b1011;
    settle();
    check("t4_grant1", 32'(ifc.grant_o), 32'h2);
    check("t4_inc",    32'(ifc.write_increment_o), 32'h1);
    check("t4_data",   32'(ifc.write_data_o), 32'hD1);
    tick();
    ifc.request_i = 4'b1001;
    settle();
    check("t4_drop_inc", 32'(ifc.write_increment_o), 32'h0);
    tick();
    check("t4_next_grant", 32'(ifc.grant_o), 32'h8);

    // Async reset mid-burst, between clock edges
    check("t5_pre_inc", 32'(ifc.write_increment_o), 32'h1);
    rst_n = 1'b0;
    settle();
    check("t5_rst_grant", 32'(ifc.grant_o), 32'h0);
    check("t5_rst_inc",   32'(ifc.write_increment_o), 32'h0);
    check("t5_rst_busy",  32'(ifc.busy_o), 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    check("t5_first_grant", 32'(ifc.grant_o), 32'h1);
    ifc.request_i = 4'b0000;
    tick();
    do_reset();

    // max_burst=1: word-level alternation between 0 and 2
    ifc1.data_i[7:0]   = 8'hE0;
    ifc1.data_i[23:16] = 8'hE2;
    ifc1.request_i     = 4'b0101;
    tick();
    for (int i = 0; i < 6; i++) begin
      settle();
      check("t6_grant", 32'(ifc1.grant_o), (i % 2 == 0) ? 32'h1 : 32'h4);
      check("t6_inc",   32'(ifc1.write_increment_o), 32'h1);
      check("t6_data",  32'(ifc1.write_data_o), (i % 2 == 0) ? 32'hE0 : 32'hE2);
      tick();
    end
    ifc1.request_i = 4'b0000;
    tick();
    check("t6_idle_grant", 32'(ifc1.grant_o), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
